// File: rtl/mem_align_unit.sv
// mem_align_unit: MEM-stage front end to DataMem that splits misaligned loads/stores (MISALIGN_TRAP_EN: trap instead of split)
module mem_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              dm_MemRead,
    output logic              dm_MemWrite,
    output logic [2:0]        dm_func3,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_data_in,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_trap,
`endif
    input  logic [31:0]       dm_data_out
);
    logic is_rd, is_wr, mis;
    logic mr, mw, st, lv;
    logic [2:0] f3;
    logic [ADDR_W-1:0] ad;
    logic [31:0] di, ld;
    assign is_wr = req_valid & req_write;
    assign is_rd = req_valid & req_read & ~req_write;
    assign mis = ((req_func3[1:0] == 2'b01) & req_addr[0]) | ((req_func3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
    logic trap;
    // aligned accesses pass through; misaligned ones raise a single-cycle trap with no DataMem access
    always_comb begin
        trap = mis & (is_rd | is_wr);
        mr = trap ? 1'b0 : is_rd;
        mw = trap ? 1'b0 : is_wr;
        f3 = req_func3;
        ad = req_addr;
        di = req_wdata;
        st = 1'b0;
        lv = trap ? 1'b0 : is_rd;
        ld = lv ? dm_data_out : 32'd0;
    end
    assign misalign_trap = rst_n & trap;
`else
    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_t;
    state_t state, state_nx;
    logic [1:0] cnt;
    logic [ADDR_W-1:0] l_addr;
    logic [2:1] l_func3;
    logic [31:0] l_wdata, lo, merged, ext_data;
    logic last;
    assign merged = 32'({dm_data_out, lo} >> {l_addr[1:0], 3'b000});
    assign ext_data = l_func3[1] ? merged : {{16{~l_func3[2] & merged[15]}}, merged[15:0]};
    assign last = cnt == (l_func3[1] ? 2'd3 : 2'd1);
    // state, byte counter and request latch; the request and low word are captured while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            lo      <= 32'd0;
            l_addr  <= '0;
            l_func3 <= 2'd0;
            l_wdata <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx == ST_BYTE) ? cnt + 2'd1 : 2'd0;
            if (state == IDLE) begin
                l_addr  <= req_addr;
                l_func3 <= req_func3[2:1];
                l_wdata <= req_wdata;
                lo      <= dm_data_out;
            end
        end
    end
    // next state and DataMem drive: pass-through, split load (two words) or split store (byte sequence)
    always_comb begin
        state_nx = state;
        mr = 1'b0;
        mw = 1'b0;
        f3 = 3'b000;
        ad = '0;
        di = 32'd0;
        st = 1'b0;
        lv = 1'b0;
        ld = 32'd0;
        case (state)
            IDLE: begin
                if (mis & is_wr) begin
                    mw = 1'b1;
                    ad = req_addr;
                    di = {24'd0, req_wdata[7:0]};
                    st = 1'b1;
                    state_nx = ST_BYTE;
                end else if (mis & is_rd) begin
                    mr = 1'b1;
                    f3 = 3'b010;
                    ad = {req_addr[ADDR_W-1:2], 2'b00};
                    st = 1'b1;
                    state_nx = LD_HI;
                end else begin
                    mr = is_rd;
                    mw = is_wr;
                    f3 = req_func3;
                    ad = req_addr;
                    di = req_wdata;
                    lv = is_rd;
                    ld = is_rd ? dm_data_out : 32'd0;
                end
            end
            LD_HI: begin
                mr = 1'b1;
                f3 = 3'b010;
                ad = {l_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                lv = 1'b1;
                ld = ext_data;
                state_nx = IDLE;
            end
            ST_BYTE: begin
                mw = 1'b1;
                ad = l_addr + ADDR_W'(cnt);
                di = {24'd0, l_wdata[8*cnt +: 8]};
                st = ~last;
                state_nx = last ? IDLE : ST_BYTE;
            end
            default: state_nx = IDLE;
        endcase
    end
`endif
    assign stall       = rst_n & st;
    assign load_valid  = rst_n & lv;
    assign load_data   = rst_n ? ld : 32'd0;
    assign dm_MemRead  = rst_n & mr;
    assign dm_MemWrite = rst_n & mw;
    assign dm_func3    = rst_n ? f3 : 3'd0;
    assign dm_addr     = rst_n ? ad : '0;
    assign dm_data_in  = rst_n ? di : 32'd0;
endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: directed vector bench for mem_align_unit with a byte-array DataMem model
module tb_mem_align_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [2:0] req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic stall, load_valid, dm_MemRead, dm_MemWrite;
    logic [31:0] load_data, dm_addr, dm_data_in, dm_data_out;
    logic [2:0] dm_func3;
`ifdef MISALIGN_TRAP_EN
    logic misalign_trap;
`endif
    int checks = 0, failures = 0;

    mem_align_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
        .dm_func3(dm_func3), .dm_addr(dm_addr), .dm_data_in(dm_data_in),
`ifdef MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
`endif
        .dm_data_out(dm_data_out)
    );

    always #5 clk = ~clk;

    // DataMem model: 64 bytes, address wraps on the low 6 bits, combinational extended read
    logic [7:0] mem [0:63];
    logic [5:0] ma;
    logic [7:0] b0, b1, b2, b3;
    assign ma = dm_addr[5:0];
    assign b0 = mem[ma];
    assign b1 = mem[ma + 6'd1];
    assign b2 = mem[ma + 6'd2];
    assign b3 = mem[ma + 6'd3];
    always_comb begin
        case (dm_func3)
            3'b000: dm_data_out = {{24{b0[7]}}, b0};
            3'b100: dm_data_out = {24'd0, b0};
            3'b001: dm_data_out = {{16{b1[7]}}, b1, b0};
            3'b101: dm_data_out = {16'd0, b1, b0};
            default: dm_data_out = {b3, b2, b1, b0};
        endcase
    end
    always @(posedge clk) begin
        if (dm_MemWrite) begin
            mem[ma] <= dm_data_in[7:0];
            if (dm_func3[1:0] != 2'b00) mem[ma + 6'd1] <= dm_data_in[15:8];
            if (dm_func3[1]) begin
                mem[ma + 6'd2] <= dm_data_in[23:16];
                mem[ma + 6'd3] <= dm_data_in[31:24];
            end
        end
    end

    typedef struct {
        logic v, r, w;
        logic [2:0] f;
        logic [31:0] a, d;
        logic st, lv;
        logic [31:0] ld;
        logic mr, mw;
        logic [2:0] df;
        logic [31:0] da, di;
    } vec_t;

    function automatic vec_t mk(logic v, r, w, logic [2:0] f, logic [31:0] a, d, logic st, lv,
                                logic [31:0] ld, logic mr, mw, logic [2:0] df, logic [31:0] da, di);
        vec_t e;
        e.v = v; e.r = r; e.w = w; e.f = f; e.a = a; e.d = d; e.st = st; e.lv = lv;
        e.ld = ld; e.mr = mr; e.mw = mw; e.df = df; e.da = da; e.di = di;
        return e;
    endfunction

    task automatic cmp(input string n, input logic [102:0] act, input logic [102:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t e);
        req_valid = e.v; req_read = e.r; req_write = e.w;
        req_func3 = e.f; req_addr = e.a; req_wdata = e.d;
    endtask

    task automatic chk(input string n, input vec_t e);
        logic [102:0] a, x;
        x = {e.st, e.lv, e.lv ? e.ld : 32'd0, e.mr, e.mw,
             (e.mr | e.mw) ? {e.df, e.da} : 35'd0, e.mw ? e.di : 32'd0};
        a = {stall, load_valid, e.lv ? load_data : 32'd0, dm_MemRead, dm_MemWrite,
             (e.mr | e.mw) ? {dm_func3, dm_addr} : 35'd0, e.mw ? dm_data_in : 32'd0};
        cmp(n, a, x);
    endtask

    function automatic logic [102:0] all_out();
        return {stall, load_valid, load_data, dm_MemRead, dm_MemWrite, dm_func3, dm_addr, dm_data_in};
    endfunction

    vec_t tv [21];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        drive(mk(1, 0, 1, 3'b010, 32'd1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        cmp("reset_outputs", all_out(), 103'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 3'b010, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        cmp("trap_lw2", {misalign_trap, stall, dm_MemRead, dm_MemWrite, load_valid}, 103'b10000);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        cmp("trap_drop", {misalign_trap, stall, dm_MemRead, dm_MemWrite, load_valid}, 103'b00000);
        @(posedge clk); #1;
        drive(mk(1, 0, 1, 3'b010, 32'd0, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        cmp("trap_aligned_sw", {misalign_trap, stall, dm_MemRead, dm_MemWrite, load_valid}, 103'b00010);
`else
        tv[0]  = mk(0, 0, 0, 3'b000, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 0, 1, 3'b010, 32'd0, 32'h6F4, 0, 0, 0, 0, 1, 3'b010, 32'd0, 32'h6F4);
        tv[2]  = mk(1, 1, 0, 3'b000, 32'd0, 32'd0, 0, 1, 32'hFFFFFFF4, 1, 0, 3'b000, 32'd0, 0);
        tv[3]  = mk(1, 1, 0, 3'b100, 32'd0, 32'd0, 0, 1, 32'h000000F4, 1, 0, 3'b100, 32'd0, 0);
        tv[4]  = mk(1, 0, 1, 3'b010, 32'd5, 32'h11223344, 1, 0, 0, 0, 1, 3'b000, 32'd5, 32'h44);
        tv[5]  = mk(1, 0, 1, 3'b010, 32'd5, 32'h11223344, 1, 0, 0, 0, 1, 3'b000, 32'd6, 32'h33);
        tv[6]  = mk(1, 0, 1, 3'b010, 32'd5, 32'h11223344, 1, 0, 0, 0, 1, 3'b000, 32'd7, 32'h22);
        tv[7]  = mk(1, 0, 1, 3'b010, 32'd5, 32'h11223344, 0, 0, 0, 0, 1, 3'b000, 32'd8, 32'h11);
        tv[8]  = mk(1, 1, 0, 3'b010, 32'd5, 32'd0, 1, 0, 0, 1, 0, 3'b010, 32'd4, 0);
        tv[9]  = mk(1, 1, 0, 3'b010, 32'd5, 32'd0, 0, 1, 32'h11223344, 1, 0, 3'b010, 32'd8, 0);
        tv[10] = mk(1, 0, 1, 3'b001, 32'd3, 32'h8001, 1, 0, 0, 0, 1, 3'b000, 32'd3, 32'h01);
        tv[11] = mk(1, 0, 1, 3'b001, 32'd3, 32'h8001, 0, 0, 0, 0, 1, 3'b000, 32'd4, 32'h80);
        tv[12] = mk(1, 1, 0, 3'b001, 32'd3, 32'd0, 1, 0, 0, 1, 0, 3'b010, 32'd0, 0);
        tv[13] = mk(1, 1, 0, 3'b001, 32'd3, 32'd0, 0, 1, 32'hFFFF8001, 1, 0, 3'b010, 32'd4, 0);
        tv[14] = mk(1, 1, 0, 3'b101, 32'd3, 32'd0, 1, 0, 0, 1, 0, 3'b010, 32'd0, 0);
        tv[15] = mk(1, 1, 0, 3'b101, 32'd3, 32'd0, 0, 1, 32'h00008001, 1, 0, 3'b010, 32'd4, 0);
        tv[16] = mk(1, 1, 0, 3'b010, 32'hFFFFFFFE, 0, 1, 0, 0, 1, 0, 3'b010, 32'hFFFFFFFC, 0);
        tv[17] = mk(1, 1, 0, 3'b010, 32'hFFFFFFFE, 0, 0, 1, 32'h06F40000, 1, 0, 3'b010, 32'h00000000, 0);
        tv[18] = mk(1, 1, 1, 3'b010, 32'd8, 32'hCAFEBABE, 0, 0, 0, 0, 1, 3'b010, 32'd8, 32'hCAFEBABE);
        tv[19] = mk(1, 1, 0, 3'b010, 32'd8, 32'd0, 0, 1, 32'hCAFEBABE, 1, 0, 3'b010, 32'd8, 0);
        tv[20] = mk(1, 1, 0, 3'b101, 32'd2, 32'd0, 0, 1, 32'h00000100, 1, 0, 3'b101, 32'd2, 0);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("row%0d", i), tv[i]);
        end
        // store aborted by reset during its second byte
        @(posedge clk); #1;
        drive(mk(1, 0, 1, 3'b010, 32'd1, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("rst_st_b0", mk(1, 0, 1, 3'b010, 32'd1, 0, 1, 0, 0, 0, 1, 3'b000, 32'd1, 32'hDD));
        @(posedge clk); #1;
        chk("rst_st_b1", mk(1, 0, 1, 3'b010, 32'd1, 0, 1, 0, 0, 0, 1, 3'b000, 32'd2, 32'hCC));
        rst_n = 1'b0;
        #1;
        cmp("rst_abort", all_out(), 103'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 3'b010, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("post_rst_lw", mk(1, 1, 0, 3'b010, 32'd0, 0, 0, 1, 32'h0100DDF4, 1, 0, 3'b010, 32'd0, 0));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- MEM-stage front end sitting directly upstream of DataMem; it drives DataMem's MemRead, MemWrite, func3, addr and data_in ports and consumes its data_out.
- Aligned loads and stores pass straight through in the same cycle.
- Misaligned accesses are split into multiple DataMem accesses, with a pipeline stall.
- Misaligned loads: two aligned word reads, merged and then sign/zero-extended here. Misaligned stores: a sequence of byte stores.

Parameters:
- ADDR_W, 32, address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage request present
- req_read  in  1  load request (pipeline MemRead)
- req_write  in  1  store request (pipeline MemWrite)
- req_func3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- stall  out  1  hold pipeline; request inputs must stay stable while high
- load_valid  out  1  load_data valid this cycle
- load_data  out  32  extended load result
- dm_MemRead  out  1  to DataMem MemRead
- dm_MemWrite  out  1  to DataMem MemWrite
- dm_func3  out  3  to DataMem func3
- dm_addr  out  ADDR_W  to DataMem addr
- dm_data_in  out  32  to DataMem data_in
- dm_data_out  in  32  from DataMem data_out (combinational read)

Behaviour:
- Reset and idle conditions:
  - rst_n low: state=IDLE, byte counter=0, lo latch=0.
  - rst_n low: all outputs 0 (stall, load_valid, load_data, all dm_*). dm_MemWrite is forced 0 immediately, not at the next edge.
  - req_valid=0: all dm enables 0, stall 0, load_valid 0.
  - req_read and req_write both 1: treated as store; load_valid stays 0.
- Misalignment rule:
  - Halfword is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]!=00.
  - Byte accesses are never misaligned.
- Aligned access (IDLE, 0 cycles added, stall 0):
  - dm_* = req_* pass-through.
  - Load: load_valid=1 and load_data=dm_data_out in the same cycle.
- FSM states: IDLE, LD_HI, ST_BYTE.
- Misaligned load:
  - Cycle 0 (IDLE): dm_MemRead=1, dm_func3=010, dm_addr=A&~3, stall=1. At the edge, latch lo=dm_data_out and go to LD_HI.
  - Cycle 1 (LD_HI): dm_addr=(A&~3)+4, stall=0, load_valid=1. Go to IDLE at the edge.
  - Merge: load_data = ({dm_data_out,lo} >> 8*A[1:0]), truncated to 16 or 32 bits. For 16 bits, zero-extend if func3[2]=1, else sign-extend.
- Misaligned store of n bytes (n=2 for H, 4 for W):
  - Cycle i (i=0..n-1): dm_MemWrite=1, dm_func3=000, dm_addr=A+i, dm_data_in={24'b0, wdata[8i+7:8i]}.
  - Cycle 0 is issued from IDLE; the remaining bytes from ST_BYTE with counter i.
  - stall=1 for i<n-1 and 0 on the last byte; return to IDLE after the last byte.
- Address increments wrap modulo 2^ADDR_W, e.g. 0xFFFFFFFC+4 -> 0x00000000.
- Reset mid-sequence aborts the access; partially written bytes remain in memory.
- In LD_HI and ST_BYTE, only the latched request is used; the combinational req_* decode is ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_trap (1 bit, reset 0).
  - Misaligned accesses are not split: dm enables 0, stall 0, load_valid 0, misalign_trap=1 for that cycle only.
  - FSM states LD_HI and ST_BYTE are not built.
- Undefined: the port is absent and splitting behaves as above.

Test Plan:
- SW addr 0 data 0x000006F4, then LB addr 0 -> single dm write with func3 010, stall 0; load_data=0xFFFFFFF4 same cycle; LBU gives 0x000000F4.
- SW addr 5 data 0x11223344 -> 4 cycles of SB: dm_addr 5,6,7,8, dm_data_in 0x44,0x33,0x22,0x11, stall 1,1,1,0. Then LW addr 5 -> dm_addr 4 (stall 1), then 8 (stall 0); load_data=0x11223344, load_valid on cycle 1 only.
- SH addr 3 data 0x8001 -> SB 0x01@3, 0x80@4. Then LH addr 3 -> 0xFFFF8001; LHU addr 3 -> 0x00008001.
- LW addr 0xFFFFFFFE -> first dm_addr 0xFFFFFFFC, second dm_addr 0x00000000 (wrap).
- Reset mid-store: SW addr 1 data 0xAABBCCDD, assert rst_n low during byte 1 -> dm_MemWrite and stall drop to 0 immediately; after release state is IDLE and the next aligned LW passes through.
- req_read=req_write=1, SW-type func3 010 at addr 8 -> store issued, load_valid 0. With MISALIGN_TRAP_EN: LW addr 2 -> misalign_trap 1-cycle pulse, no dm access.
